// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired x0, combinational reads and a per-register busy scoreboard.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*XLEN-1:0]  rd,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   iss_v,
  input  logic [AW-1:0]          iss_rd,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    raddr  [NREAD];
  logic             wr_en;

  assign wr_en = we && (wa != '0);

  // Writeback data update; x0 is forced to zero so it never holds a value.
  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wr_en) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  // Scoreboard: set wins over clear since the new producer is still outstanding.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < int'(NREGS); r++) begin
      busy_d[r] = (iss_v && (iss_rd == AW'(r))) ||
                  (busy_q[r] && !(we && (wa == AW'(r))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREAD); i++) begin
      raddr[i] = ra[i*AW +: AW];
    end
  end

  // Read ports; forwarding is gated by rst_n so outputs stay zero during reset.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      rd[i*XLEN +: XLEN] = regs_q[raddr[i]];
      rbusy[i]           = busy_q[raddr[i]];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && (raddr[i] == wa)) begin
        rd[i*XLEN +: XLEN] = wd;
        rbusy[i]           = iss_v && (iss_rd == wa);
      end
`endif
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard, plus reset sequences.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_v    (iss_v),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_rb0;
    logic        e_rb1;
    logic [31:0] e_bv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic iv, logic [4:0] ir,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] d0, logic [31:0] d1,
                              logic b0, logic b1, logic [31:0] bv);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.iss_v = iv; v.iss_rd = ir;
    v.ra0 = r0; v.ra1 = r1; v.e_rd0 = d0; v.e_rd1 = d1;
    v.e_rb0 = b0; v.e_rb1 = b1; v.e_bv = bv;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic w, logic [4:0] a, logic [31:0] d, logic iv, logic [4:0] ir,
                       logic [4:0] r0, logic [4:0] r1);
    we = w; wa = a; wd = d; iss_v = iv; iss_rd = ir; ra = {r1, r0};
  endtask

  task automatic check_outs(string tag, logic [31:0] d0, logic [31:0] d1,
                            logic b0, logic b1, logic [31:0] bv);
    check({tag, "_rd0"}, rd[31:0], d0);
    check({tag, "_rd1"}, rd[63:32], d1);
    check({tag, "_rbusy"}, 32'(rbusy), 32'({b1, b0}));
    check({tag, "_busy_vec"}, busy_vec, bv);
  endtask

  initial begin
    // Values sampled before each vector's clock edge, i.e. state from earlier vectors.
    vecs.push_back(mk(1, 9, 32'h4, 0, 0,  9, 9,  BYP ? 32'h4 : 32'h0, BYP ? 32'h4 : 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  9, 9,  32'h4, 32'h4, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 9, 32'h0, 32'h4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0,  0, 9,  32'h0, 32'h4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  0, 7,  32'h0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 7,  7, 0,  32'h0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  7, 0,  32'h0, 32'h0, 1, 0, 32'h80));
    vecs.push_back(mk(1, 7, 32'h12, 0, 0, 7, 7,  BYP ? 32'h12 : 32'h0, BYP ? 32'h12 : 32'h0,
                      !BYP, !BYP, 32'h80));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  7, 0,  32'h12, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3,  3, 0,  32'h0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3, 32'h33, 1, 3, 3, 0,  BYP ? 32'h33 : 32'h0, 32'h0, 1, 0, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  3, 0,  32'h33, 32'h0, 1, 0, 32'h8));
    vecs.push_back(mk(1, 12, 32'h1, 0, 0, 12, 0, BYP ? 32'h1 : 32'h0, 32'h0, 0, 0, 32'h8));
    vecs.push_back(mk(1, 12, 32'hA5A5A5A5, 0, 0, 12, 12, BYP ? 32'hA5A5A5A5 : 32'h1,
                      BYP ? 32'hA5A5A5A5 : 32'h1, 0, 0, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  12, 3, 32'hA5A5A5A5, 32'h33, 0, 1, 32'h8));
    vecs.push_back(mk(1, 3, 32'h44, 0, 0, 3, 0,  BYP ? 32'h44 : 32'h33, 32'h0, !BYP, 0, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  3, 0,  32'h44, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 5, 32'h6, 1, 9,  5, 0,  BYP ? 32'h6 : 32'h0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0,  5, 9,  32'h6, 32'h4, 0, 1, 32'h200));

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outs("reset_init", 32'h0, 32'h0, 0, 0, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].iss_v, vecs[k].iss_rd,
            vecs[k].ra0, vecs[k].ra1);
      #1;
      check_outs($sformatf("v%0d", k), vecs[k].e_rd0, vecs[k].e_rd1,
                 vecs[k].e_rb0, vecs[k].e_rb1, vecs[k].e_bv);
    end

    // Async reset mid-run: x5=6 and busy[9] must vanish without a clock edge.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 5, 9);
    #1;
    check_outs("pre_reset", 32'h6, 32'h4, 0, 1, 32'h200);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 32'h0, 32'h0, 0, 0, 32'h0);

    // Write and issue held across an edge during reset are discarded.
    drive(1, 5, 32'h77, 1, 9, 5, 9);
    @(posedge clk);
    #1;
    check_outs("reset_inflight", 32'h0, 32'h0, 0, 0, 32'h0);

    // First edge after release accepts write and issue.
    @(negedge clk);
    drive(1, 5, 32'h99, 1, 9, 5, 9);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 5, 9);
    #1;
    check_outs("post_reset", 32'h99, 32'h4 & 32'h0, 0, 1, 32'h200);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
